mem_bus_sequencer: RTL and testbench
====================================

Name: mem_bus_sequencer

Overview:
Sequences one external-memory access per request over the data-bus transceiver. It drives that transceiver's dir/oen pins and the memory strobes, and owns the CPU-side (A) data port of the transceiver. It guarantees break-before-make: the transceiver is disabled for at least one full cycle before dir changes. It sits between the CPU control logic and the bus buffer: it consumes read data from the buffer and feeds it write data.

Parameters:
ADDR_WIDTH, 16, width of addr/mem_addr
SETUP_CYCLES, 1, cycles with address valid and bus disabled before the strobe (1..15)
ACCESS_CYCLES, 2, cycles the memory strobe is asserted (1..15)
TURN_CYCLES, 1, bus-disabled cycles after access before returning to idle (1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  start access; sampled only when ready=1
we  input  1  1=write, 0=read; sampled with req
addr  input  ADDR_WIDTH  access address; sampled with req
wdata  input  8  write data; sampled with req
ready  output  1  high in IDLE (request accepted)
done  output  1  one-cycle pulse, access complete
rdata  output  8  last read data; holds until next read completes
mem_addr  output  ADDR_WIDTH  registered address to memory
mem_oe_n  output  1  memory output enable, active low
mem_we_n  output  1  memory write enable, active low
buf_dir  output  1  transceiver direction: 1=A->B (write), 0=B->A (read)
buf_oen  output  1  transceiver enable, active low
data_a  inout  8  transceiver A side; driven only during write SETUP/ACCESS/HOLD, else high-Z

Behaviour:
- Reset (async, rst_n=0) forces immediately: state=IDLE, ready=1, done=0, rdata=0, mem_addr=0, mem_oe_n=1, mem_we_n=1, buf_dir=0, buf_oen=1, data_a=Z, counter=0. Any in-flight access is abandoned; the bus is released in the same instant.
- All outputs except data_a tristate are registered; data_a drive enable is decoded from the registered state.
- States: IDLE, SETUP, ACCESS, HOLD, TURN. A 4-bit down-counter times each state; it loads (N-1) on entry and the state exits when the counter is 0.
- IDLE: ready=1. If req=1 at an edge: latch we/addr/wdata, set mem_addr=addr, set buf_dir=we (buf_oen is already 1), enter SETUP. If req=0, stay. req while not IDLE is ignored, not queued.
- SETUP (SETUP_CYCLES): buf_oen=1, strobes inactive. For a write, data_a is driven with the latched wdata.
- ACCESS (ACCESS_CYCLES): buf_oen=0. Read: mem_oe_n=0. Write: mem_we_n=0, data_a driven.
  - Read: rdata captures data_a at the edge that leaves ACCESS.
  - Read then goes to TURN. Write goes to HOLD.
- HOLD (write only, 1 cycle): mem_we_n=1, buf_oen=0, data_a still driven (data hold after strobe).
- TURN (TURN_CYCLES): buf_oen=1, mem_oe_n=1, mem_we_n=1, data_a=Z. On exit: go to IDLE with done=1 for exactly that first IDLE cycle.
- buf_dir changes only on the IDLE->SETUP edge, so buf_oen has been 1 for at least TURN_CYCLES plus the IDLE cycle before any direction change.
- Never mem_oe_n=0 and mem_we_n=0 simultaneously. Never buf_dir=0 with data_a driven.
- Latency at defaults, counted from the accepting edge to the done cycle: read 5 cycles, write 6 cycles. General formula: SETUP+ACCESS+TURN+1, plus 1 for a write (HOLD).
- Back-to-back: req=1 in the done cycle is accepted (ready=1 there). The next SETUP then begins the following cycle.
- mem_addr holds its value after completion until the next accepted request.

Test Plan:
- Reset mid-write: deassert rst_n during write ACCESS -> same cycle mem_we_n=1, buf_oen=1, data_a=Z, ready=1. After release, a read req completes normally.
- Read at defaults: req=1, we=0, addr=0x1234, memory model drives 0xA5 on the B side -> mem_oe_n low exactly 2 cycles, buf_dir=0, rdata=0xA5, done pulses 5 cycles after the accepting edge, then ready=1.
- Write at defaults: req=1, we=1, addr=0x00FF, wdata=0x3C -> data_a=0x3C from SETUP through HOLD, mem_we_n low exactly 2 cycles, buf_oen low 3 cycles, done 6 cycles after the accepting edge.
- Turnaround: write then immediate read (req held high across done) -> buf_oen=1 for at least 2 consecutive cycles around the buf_dir 1->0 change; checker flags any dir change while oen=0.
- Ignored request: pulse req with we=1 during a read ACCESS -> no effect, rdata and the read timing unchanged, and no extra done pulse.
- Parameter sweep: SETUP=3, ACCESS=1, TURN=2 read -> mem_oe_n low 1 cycle, done 7 cycles after the accepting edge. Assertion run: mem_oe_n and mem_we_n are never both low.

Source files
------------

// File: rtl/mem_bus_sequencer.sv
// External-memory access sequencer: one access per request through the data-bus
// transceiver, with break-before-make handling of the transceiver direction.
module mem_bus_sequencer #(
    parameter int ADDR_WIDTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int TURN_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic                  ready,
    output logic                  done,
    output logic [7:0]            rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe_n,
    output logic                  mem_we_n,
    output logic                  buf_dir,
    output logic                  buf_oen,
    inout  tri logic [7:0]        data_a
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        TURN
    } state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES - 1);

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  we_q, we_nx;
    logic [7:0]            wdata_q, wdata_nx;
    logic [7:0]            rdata_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic                  buf_dir_nx;
    logic                  ready_nx, done_nx, buf_oen_nx, mem_oe_n_nx, mem_we_n_nx;
    logic                  drive_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            buf_dir  <= 1'b0;
            buf_oen  <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            we_q     <= we_nx;
            wdata_q  <= wdata_nx;
            ready    <= ready_nx;
            done     <= done_nx;
            rdata    <= rdata_nx;
            mem_addr <= mem_addr_nx;
            mem_oe_n <= mem_oe_n_nx;
            mem_we_n <= mem_we_n_nx;
            buf_dir  <= buf_dir_nx;
            buf_oen  <= buf_oen_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        we_nx       = we_q;
        wdata_nx    = wdata_q;
        rdata_nx    = rdata;
        mem_addr_nx = mem_addr;
        buf_dir_nx  = buf_dir;

        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx    = SETUP;
                    cnt_nx      = SETUP_LOAD;
                    we_nx       = we;
                    wdata_nx    = wdata;
                    mem_addr_nx = addr;
                    buf_dir_nx  = we;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nx = ACCESS;
                    cnt_nx   = ACCESS_LOAD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    if (we_q) begin
                        state_nx = HOLD;
                        cnt_nx   = '0;
                    end else begin
                        rdata_nx = data_a;
                        state_nx = TURN;
                        cnt_nx   = TURN_LOAD;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_nx = TURN;
                cnt_nx   = TURN_LOAD;
            end
            TURN: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Registered outputs are decoded from the state being entered.
        ready_nx    = (state_nx == IDLE);
        done_nx     = (state == TURN) && (state_nx == IDLE);
        buf_oen_nx  = !((state_nx == ACCESS) || (state_nx == HOLD));
        mem_oe_n_nx = !((state_nx == ACCESS) && !we_nx);
        mem_we_n_nx = !((state_nx == ACCESS) && we_nx);
    end

    assign drive_a = we_q && ((state == SETUP) || (state == ACCESS) || (state == HOLD));
    assign data_a  = drive_a ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed self-checking bench for mem_bus_sequencer: default-parameter instance plus
// a SETUP=3/ACCESS=1/TURN=2 instance, each with a simple B-side memory model.
module tb_mem_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req2, we;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic        ready, done, mem_oe_n, mem_we_n, buf_dir, buf_oen;
    logic [7:0]  rdata;
    logic [15:0] mem_addr;
    tri1  [7:0]  data_a;
    logic [7:0]  mem_val;

    logic        ready2, done2, mem_oe_n2, mem_we_n2, buf_dir2, buf_oen2;
    logic [7:0]  rdata2;
    logic [15:0] mem_addr2;
    tri1  [7:0]  data_a2;
    logic [7:0]  mem_val2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Transceiver B->A path: memory data appears on the A side when enabled for reads.
    assign data_a  = (!buf_oen && !buf_dir) ? mem_val : 8'bz;
    assign data_a2 = (!buf_oen2 && !buf_dir2) ? mem_val2 : 8'bz;

    mem_bus_sequencer #(
        .ADDR_WIDTH(16), .SETUP_CYCLES(1), .ACCESS_CYCLES(2), .TURN_CYCLES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .mem_addr(mem_addr),
        .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .buf_dir(buf_dir), .buf_oen(buf_oen),
        .data_a(data_a)
    );

    mem_bus_sequencer #(
        .ADDR_WIDTH(16), .SETUP_CYCLES(3), .ACCESS_CYCLES(1), .TURN_CYCLES(2)
    ) dut_sweep (
        .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready2), .done(done2), .rdata(rdata2), .mem_addr(mem_addr2),
        .mem_oe_n(mem_oe_n2), .mem_we_n(mem_we_n2), .buf_dir(buf_dir2), .buf_oen(buf_oen2),
        .data_a(data_a2)
    );

    logic prev_dir = 1'b0;
    logic prev_dir2 = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!mem_oe_n && !mem_we_n) begin
                failed++;
                $display("FAIL strobe_overlap: oe_n=%b we_n=%b required not both 0", mem_oe_n, mem_we_n);
            end
            if (!mem_oe_n2 && !mem_we_n2) begin
                failed++;
                $display("FAIL strobe_overlap_sweep: oe_n=%b we_n=%b required not both 0", mem_oe_n2, mem_we_n2);
            end
            if (buf_dir !== prev_dir && buf_oen === 1'b0) begin
                failed++;
                $display("FAIL dir_change_oen: dir %b->%b with oen=%b required oen=1", prev_dir, buf_dir, buf_oen);
            end
            if (buf_dir2 !== prev_dir2 && buf_oen2 === 1'b0) begin
                failed++;
                $display("FAIL dir_change_oen_sweep: dir %b->%b with oen=%b required oen=1", prev_dir2, buf_dir2, buf_oen2);
            end
        end
        prev_dir  = buf_dir;
        prev_dir2 = buf_dir2;
    end

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_val = 8'h00; mem_val2 = 8'h00;
        #12;
        tests++;
        if ({ready, done, mem_oe_n, mem_we_n, buf_dir, buf_oen} !== 6'b101101) begin
            failed++;
            $display("FAIL reset_ctrl: {ready,done,oe_n,we_n,dir,oen}=%b required 101101",
                     {ready, done, mem_oe_n, mem_we_n, buf_dir, buf_oen});
        end
        tests++;
        if (rdata !== 8'h00 || mem_addr !== 16'h0000 || data_a !== 8'hFF) begin
            failed++;
            $display("FAIL reset_data: rdata=%h mem_addr=%h data_a=%h required 00 0000 FF(released)",
                     rdata, mem_addr, data_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0] oe_mask, done_mask;
        oe_mask = '0; done_mask = '0;
        mem_val = 8'hA5;
        req = 1'b1; we = 1'b0; addr = 16'h1234; wdata = 8'h00;
        @(negedge clk);
        req = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (n == 1) begin
                tests++;
                if (buf_dir !== 1'b0 || ready !== 1'b0 || data_a !== 8'hFF) begin
                    failed++;
                    $display("FAIL rd_setup: dir=%b ready=%b data_a=%h required 0 0 FF", buf_dir, ready, data_a);
                end
            end
            oe_mask[n-1]   = !mem_oe_n;
            done_mask[n-1] = done;
            @(negedge clk);
        end
        tests++;
        if (oe_mask !== 8'b0000_0110) begin
            failed++;
            $display("FAIL rd_oe_window: got %b required 00000110", oe_mask);
        end
        tests++;
        if (done_mask !== 8'b0001_0000) begin
            failed++;
            $display("FAIL rd_done_cycle: got %b required 00010000", done_mask);
        end
        tests++;
        if (rdata !== 8'hA5 || mem_addr !== 16'h1234 || ready !== 1'b1) begin
            failed++;
            $display("FAIL rd_result: rdata=%h mem_addr=%h ready=%b required A5 1234 1", rdata, mem_addr, ready);
        end
    endtask

    task automatic test_write();
        logic [7:0] drv_mask, oen_mask, we_mask, oe_mask, done_mask;
        drv_mask = '0; oen_mask = '0; we_mask = '0; oe_mask = '0; done_mask = '0;
        req = 1'b1; we = 1'b1; addr = 16'h00FF; wdata = 8'h3C;
        @(negedge clk);
        req = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (n == 1) begin
                tests++;
                if (buf_dir !== 1'b1 || buf_oen !== 1'b1) begin
                    failed++;
                    $display("FAIL wr_setup: dir=%b oen=%b required 1 1", buf_dir, buf_oen);
                end
            end
            drv_mask[n-1]  = (data_a === 8'h3C);
            oen_mask[n-1]  = !buf_oen;
            we_mask[n-1]   = !mem_we_n;
            oe_mask[n-1]   = !mem_oe_n;
            done_mask[n-1] = done;
            @(negedge clk);
        end
        tests++;
        if (drv_mask !== 8'b0000_1111) begin
            failed++;
            $display("FAIL wr_data_window: got %b required 00001111", drv_mask);
        end
        tests++;
        if (we_mask !== 8'b0000_0110 || oe_mask !== 8'b0000_0000) begin
            failed++;
            $display("FAIL wr_strobe_window: we=%b oe=%b required 00000110 00000000", we_mask, oe_mask);
        end
        tests++;
        if (oen_mask !== 8'b0000_1110) begin
            failed++;
            $display("FAIL wr_oen_window: got %b required 00001110", oen_mask);
        end
        tests++;
        if (done_mask !== 8'b0010_0000) begin
            failed++;
            $display("FAIL wr_done_cycle: got %b required 00100000", done_mask);
        end
        tests++;
        if (data_a !== 8'hFF || mem_addr !== 16'h00FF) begin
            failed++;
            $display("FAIL wr_release: data_a=%h mem_addr=%h required FF 00FF", data_a, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] done_mask;
        logic [1:0]  oen_pair;
        int          change_at;
        logic        pdir, poen;
        done_mask = '0; oen_pair = '0; change_at = 0;
        pdir = buf_dir; poen = buf_oen;
        mem_val = 8'h4B;
        req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 8'h99;
        @(negedge clk);
        we = 1'b0; addr = 16'h0011;
        for (int n = 1; n <= 14; n++) begin
            if (n == 7) req = 1'b0;
            if (n > 1 && buf_dir !== pdir) begin
                change_at = n;
                oen_pair  = {poen, buf_oen};
            end
            done_mask[n-1] = done;
            pdir = buf_dir; poen = buf_oen;
            @(negedge clk);
        end
        tests++;
        if (change_at != 7 || oen_pair !== 2'b11) begin
            failed++;
            $display("FAIL turn_dir_change: at cycle %0d oen(prev,cur)=%b required cycle 7 and 11", change_at, oen_pair);
        end
        tests++;
        if (done_mask !== 14'b00_0100_0010_0000) begin
            failed++;
            $display("FAIL turn_done_cycles: got %b required 00010000100000", done_mask);
        end
        tests++;
        if (rdata !== 8'h4B || mem_addr !== 16'h0011) begin
            failed++;
            $display("FAIL turn_read_result: rdata=%h mem_addr=%h required 4B 0011", rdata, mem_addr);
        end
    endtask

    task automatic test_ignored_req();
        logic [9:0] oe_mask, we_mask, done_mask;
        oe_mask = '0; we_mask = '0; done_mask = '0;
        mem_val = 8'h5E;
        req = 1'b1; we = 1'b0; addr = 16'h0042; wdata = 8'h00;
        @(negedge clk);
        req = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            oe_mask[n-1]   = !mem_oe_n;
            we_mask[n-1]   = !mem_we_n;
            done_mask[n-1] = done;
            if (n == 2) begin
                req = 1'b1; we = 1'b1; addr = 16'hBEEF; wdata = 8'hFF;
            end else if (n == 3) begin
                req = 1'b0; we = 1'b0;
            end
            @(negedge clk);
        end
        tests++;
        if (oe_mask !== 10'b00_0000_0110 || we_mask !== 10'b00_0000_0000) begin
            failed++;
            $display("FAIL ign_strobes: oe=%b we=%b required 0000000110 0000000000", oe_mask, we_mask);
        end
        tests++;
        if (done_mask !== 10'b00_0001_0000) begin
            failed++;
            $display("FAIL ign_done: got %b required 0000010000", done_mask);
        end
        tests++;
        if (rdata !== 8'h5E || mem_addr !== 16'h0042) begin
            failed++;
            $display("FAIL ign_result: rdata=%h mem_addr=%h required 5E 0042", rdata, mem_addr);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] done_mask;
        done_mask = '0;
        req = 1'b1; we = 1'b1; addr = 16'h0100; wdata = 8'h3C;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_we_n !== 1'b0 || buf_oen !== 1'b0 || data_a !== 8'h3C) begin
            failed++;
            $display("FAIL rst_pre_access: we_n=%b oen=%b data_a=%h required 0 0 3C", mem_we_n, buf_oen, data_a);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_we_n !== 1'b1 || buf_oen !== 1'b1 || data_a !== 8'hFF || ready !== 1'b1) begin
            failed++;
            $display("FAIL rst_async_release: we_n=%b oen=%b data_a=%h ready=%b required 1 1 FF 1",
                     mem_we_n, buf_oen, data_a, ready);
        end
        tests++;
        if (rdata !== 8'h00 || mem_addr !== 16'h0000 || buf_dir !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL rst_async_regs: rdata=%h mem_addr=%h dir=%b done=%b required 00 0000 0 0",
                     rdata, mem_addr, buf_dir, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_val = 8'h81;
        req = 1'b1; we = 1'b0; addr = 16'h0200;
        @(negedge clk);
        req = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            done_mask[n-1] = done;
            @(negedge clk);
        end
        tests++;
        if (done_mask !== 8'b0001_0000 || rdata !== 8'h81) begin
            failed++;
            $display("FAIL rst_then_read: done=%b rdata=%h required 00010000 81", done_mask, rdata);
        end
    endtask

    task automatic test_param_sweep();
        logic [9:0] oe_mask, done_mask;
        oe_mask = '0; done_mask = '0;
        mem_val2 = 8'h77;
        req2 = 1'b1; we = 1'b0; addr = 16'h0ABC;
        @(negedge clk);
        req2 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            oe_mask[n-1]   = !mem_oe_n2;
            done_mask[n-1] = done2;
            @(negedge clk);
        end
        tests++;
        if (oe_mask !== 10'b00_0000_1000) begin
            failed++;
            $display("FAIL sweep_oe_window: got %b required 0000001000", oe_mask);
        end
        tests++;
        if (done_mask !== 10'b00_0100_0000) begin
            failed++;
            $display("FAIL sweep_done_cycle: got %b required 0001000000", done_mask);
        end
        tests++;
        if (rdata2 !== 8'h77 || mem_addr2 !== 16'h0ABC || ready2 !== 1'b1) begin
            failed++;
            $display("FAIL sweep_result: rdata=%h mem_addr=%h ready=%b required 77 0ABC 1", rdata2, mem_addr2, ready2);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_ignored_req();
        test_reset_mid_write();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
